fft_frame_arbiter: RTL and testbench

Round-robin scheduler that shares one radix-2 DIT FFT core between NCH streaming sources on a whole-frame basis. A source raises a request when it holds a complete N-sample frame. The arbiter grants one source at a time, forwards exactly N samples into the core with the source index carried in the core's metadata field, and flags protocol violations. It sits directly in front of the dit core; output samples are steered back by the channel field that returns on the core's out_m.

---
 rtl/fft_arb_pkg.sv | 8 +
 rtl/fft_frame_arbiter_rr_pick.sv | 27 ++
 rtl/fft_frame_arbiter.sv | 111 +++++++++++
 tb/tb_fft_frame_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fft_arb_pkg.sv
// fft_arb_pkg: shared types and widths for the FFT frame arbiter.
package fft_arb_pkg;
    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_GAP} arb_state_e;
    localparam int GAP_W = 4;
    function automatic int cnt_w(input int log_n);
        return log_n + 1;
    endfunction
endpackage

// File: rtl/fft_frame_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, lowest requester strictly above last_ch with wrap.
module rr_pick #(
    parameter int NCH = 2,
    parameter int CHW = 1
) (
    input  logic [NCH-1:0] req,
    input  logic [CHW-1:0] last_ch,
    output logic [NCH-1:0] win,
    output logic [CHW-1:0] idx
);
    int  c;
    logic found;
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int i = 1; i <= NCH; i++) begin
            c = (int'(last_ch) + i) % NCH;
            if (!found && req[c]) begin
                found  = 1'b1;
                win[c] = 1'b1;
                idx    = CHW'(c);
            end
        end
    end
endmodule

// File: rtl/fft_frame_arbiter.sv
// fft_frame_arbiter: round-robin whole-frame scheduler in front of a shared FFT core.
// Optional protocol checking is enabled by defining FFT_ARB_ERRCHK_EN.
module fft_frame_arbiter
    import fft_arb_pkg::*;
#(
    parameter int N      = 16,
    parameter int LOG_N  = 4,
    parameter int WIDTH  = 32,
    parameter int MWIDTH = 1,
    parameter int NCH    = 2,
    parameter int CHW    = 1,
    parameter int GAP    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        req,
    input  logic [NCH*WIDTH-1:0]  src_data,
    input  logic [NCH-1:0]        src_nd,
    input  logic [NCH*MWIDTH-1:0] src_m,
    output logic [NCH-1:0]        gnt,
    output logic [WIDTH-1:0]      core_data,
    output logic                  core_nd,
    output logic [CHW+MWIDTH-1:0] core_m,
    input  logic [CHW+MWIDTH-1:0] core_out_m,
    output logic [CHW-1:0]        out_ch,
    output logic                  busy,
    output logic                  error
);
    localparam int CNT_W = cnt_w(LOG_N);

    arb_state_e       state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [CHW-1:0]   cur_ch, last_ch, win_idx;
    logic [NCH-1:0]   win;
    logic             sel_nd, last_sample, gap_done, unused;

    rr_pick #(.NCH(NCH), .CHW(CHW)) u_pick (
        .req(req),
        .last_ch(last_ch),
        .win(win),
        .idx(win_idx)
    );

    assign sel_nd      = src_nd[cur_ch];
    assign last_sample = state == S_STREAM && sel_nd && cnt == CNT_W'(N - 1);
    assign gap_done    = gap_cnt == GAP_W'(1);
    assign busy        = state != S_IDLE;
    assign out_ch      = core_out_m[CHW+MWIDTH-1 -: CHW];
    assign unused      = &{1'b0, core_out_m[MWIDTH-1:0]};

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= S_IDLE;
        else     state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   state_n = |req ? S_STREAM : S_IDLE;
            S_STREAM: state_n = last_sample ? (GAP == 0 ? S_IDLE : S_GAP) : S_STREAM;
            S_GAP:    state_n = gap_done ? S_IDLE : S_GAP;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt       <= '0;
            cur_ch    <= '0;
            last_ch   <= CHW'(NCH - 1);
            cnt       <= '0;
            gap_cnt   <= '0;
            core_data <= '0;
            core_nd   <= 1'b0;
            core_m    <= '0;
        end else begin
            core_nd <= 1'b0;
            if (state == S_IDLE && |req) begin
                gnt    <= win;
                cur_ch <= win_idx;
                cnt    <= '0;
            end
            if (state == S_STREAM && sel_nd) begin
                core_data <= src_data[cur_ch*WIDTH +: WIDTH];
                core_m    <= {cur_ch, src_m[cur_ch*MWIDTH +: MWIDTH]};
                core_nd   <= 1'b1;
                cnt       <= cnt + 1'b1;
            end
            // gap_cnt is loaded with GAP so the GAP state lasts exactly GAP cycles
            if (last_sample) begin
                gnt     <= '0;
                last_ch <= cur_ch;
                gap_cnt <= GAP_W'(GAP);
            end else if (state == S_GAP) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

`ifdef FFT_ARB_ERRCHK_EN
    logic err_now;
    assign err_now = |(src_nd & ~gnt & ~req)
                   || (state == S_STREAM && !req[cur_ch] && !last_sample)
                   || (state != S_STREAM && sel_nd);
    always_ff @(posedge clk or posedge rst)
        if (rst)          error <= 1'b0;
        else if (err_now) error <= 1'b1;
`else
    assign error = 1'b0;
`endif
endmodule

// File: tb/tb_fft_frame_arbiter.sv
// tb_fft_frame_arbiter: directed self-checking bench for fft_frame_arbiter (default parameters).
module tb_fft_frame_arbiter;
    localparam int N = 16;
`ifdef FFT_ARB_ERRCHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, man_nd, src_nd, src_m, gnt, core_m, core_out_m;
    logic [63:0] src_data;
    logic [31:0] core_data;
    logic        core_nd, out_ch, busy, error;
    logic        auto_en;
    int          checks = 0;
    int          errors = 0;

    assign src_nd = man_nd | (auto_en ? gnt : 2'b00);
    always #5 clk = ~clk;

    fft_frame_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .src_data(src_data), .src_nd(src_nd),
        .src_m(src_m), .gnt(gnt), .core_data(core_data), .core_nd(core_nd),
        .core_m(core_m), .core_out_m(core_out_m), .out_ch(out_ch),
        .busy(busy), .error(error)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        int rise[4];
        int chs[4];
        int nr, pulses;
        logic prev;
        rst = 1'b1; req = '0; man_nd = '0; src_data = '0; src_m = '0;
        core_out_m = '0; auto_en = 1'b0;
        step();
        check("rst_gnt", 64'(gnt), 0);
        check("rst_nd", 64'(core_nd), 0);
        check("rst_data", 64'(core_data), 0);
        check("rst_m", 64'(core_m), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_err", 64'(error), 0);
        step();
        rst = 1'b0;
        step();

        // single frame from source 0
        req = 2'b01;
        step();
        check("t1_gnt", 64'(gnt), 64'h1);
        check("t1_busy", 64'(busy), 1);
        for (int k = 0; k < N; k++) begin
            src_data[31:0] = 32'(32'h10000 * (k + 1));
            src_m = 2'(k & 1);
            man_nd = 2'b01;
            step();
            check("t1_nd", 64'(core_nd), 1);
            check("t1_data", 64'(core_data), 64'(32'h10000 * (k + 1)));
            check("t1_m", 64'(core_m), 64'(k & 1));
            check("t1_gnt_hold", 64'(gnt), k < N - 1 ? 64'h1 : 64'h0);
        end
        man_nd = '0; req = '0;
        check("t1_busy_gap0", 64'(busy), 1);
        step();
        check("t1_nd_off", 64'(core_nd), 0);
        check("t1_data_hold", 64'(core_data), 64'h100000);
        check("t1_busy_gap1", 64'(busy), 1);
        step();
        check("t1_busy_idle", 64'(busy), 0);

        // continuous requests from both sources
        do_reset();
        src_data = {32'hBBBB0000, 32'hAAAA0000};
        src_m = '0;
        nr = 0; prev = 1'b0;
        for (int c = 0; c < 4; c++) begin rise[c] = 0; chs[c] = 9; end
        req = 2'b11; auto_en = 1'b1;
        for (int c = 0; c < 75; c++) begin
            step();
            if (core_nd && !prev && nr < 4) begin
                rise[nr] = c;
                chs[nr] = int'(core_m[1]);
                nr++;
            end
            prev = core_nd;
        end
        check("t2_frames", 64'(nr), 4);
        check("t2_ch0", 64'(chs[0]), 0);
        check("t2_ch1", 64'(chs[1]), 1);
        check("t2_ch2", 64'(chs[2]), 0);
        check("t2_ch3", 64'(chs[3]), 1);
        check("t2_sp01", 64'(rise[1] - rise[0]), 19);
        check("t2_sp12", 64'(rise[2] - rise[1]), 19);
        check("t2_sp23", 64'(rise[3] - rise[2]), 19);
        auto_en = 1'b0; req = '0;
        do_reset();

        // source 1 streams without request while source 0 is granted
        req = 2'b01;
        step();
        check("t3_gnt", 64'(gnt), 64'h1);
        for (int k = 0; k < N; k++) begin
            src_data = {32'hDEADBEEF, 32'(32'h10000 * (k + 1))};
            man_nd = k == 3 ? 2'b11 : 2'b01;
            step();
            check("t3_data", 64'(core_data), 64'(32'h10000 * (k + 1)));
            if (k == 3) check("t3_err_set", 64'(error), 64'(ERR_EXP));
        end
        man_nd = '0; req = '0;
        step();
        check("t3_err_sticky", 64'(error), 64'(ERR_EXP));
        step();
        step();

        // asynchronous reset mid-frame, then gapped frame
        req = 2'b01;
        step();
        check("t4_gnt", 64'(gnt), 64'h1);
        for (int k = 0; k < 8; k++) begin
            src_data[31:0] = 32'(k + 1);
            man_nd = 2'b01;
            step();
        end
        check("t4_pre_nd", 64'(core_nd), 1);
        #1 rst = 1'b1;
        #1;
        check("t4_arst_gnt", 64'(gnt), 0);
        check("t4_arst_nd", 64'(core_nd), 0);
        check("t4_arst_data", 64'(core_data), 0);
        check("t4_arst_m", 64'(core_m), 0);
        check("t4_arst_busy", 64'(busy), 0);
        check("t4_arst_err", 64'(error), 0);
        man_nd = '0;
        step();
        rst = 1'b0;
        req = 2'b11;
        step();
        check("t4_regnt", 64'(gnt), 64'h1);
        pulses = 0;
        for (int k = 0; k < N; k++) begin
            src_data[31:0] = 32'(32'h500 + k);
            man_nd = 2'b01;
            step();
            pulses += int'(core_nd);
            check("t5_data", 64'(core_data), 64'(32'h500 + k));
            check("t5_gnt", 64'(gnt), k < N - 1 ? 64'h1 : 64'h0);
            man_nd = 2'b00;
            step();
            pulses += int'(core_nd);
        end
        check("t5_pulses", 64'(pulses), 16);
        check("t5_err", 64'(error), 0);
        req = '0;
        step();
        step();
        check("t5_idle", 64'(busy), 0);

        // channel field from core output metadata
        core_out_m = 2'b10;
        #1;
        check("t6_ch1", 64'(out_ch), 1);
        core_out_m = 2'b01;
        #1;
        check("t6_ch0", 64'(out_ch), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
